// File: rtl/circle_ring_sequencer.sv
// Circle-ring animation sequencer: walks one circle around the upper/lower rows of a
// seven-segment ring while time-multiplexing the digit anodes for a shared encoder.
module circle_ring_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter bit led_logic  = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  run_i,
  input  logic                                  dir_i,
  input  logic                                  clear_i,
  input  logic                                  blank_i,
  output logic                                  row_o,
  output logic                                  enable_o,
  output logic [NUM_DIGITS-1:0]                 anode_o,
  output logic [$clog2(2*NUM_DIGITS)-1:0]       pos_o,
  output logic                                  step_o
);

  localparam int POS_W  = $clog2(2*NUM_DIGITS);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(2*NUM_DIGITS-1);
  localparam logic [POS_W-1:0]  POS_UPPER = POS_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS-1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV-1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV-1);

  logic [POS_W-1:0]      pos;
  logic [POS_W-1:0]      pos_next;
  logic [POS_W-1:0]      digit;
  logic [STEP_W-1:0]     step_cnt;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    pos_next = pos;
    if (dir_i) begin
      pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
    end else begin
      pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
    end
  end

  // Animation: clear wins over a coincident step; pausing freezes the partial count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos      <= '0;
      step_cnt <= '0;
      step_o   <= 1'b0;
    end else if (clear_i) begin
      pos      <= '0;
      step_cnt <= '0;
      step_o   <= 1'b0;
    end else if (run_i) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        pos      <= pos_next;
        step_o   <= 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
        step_o   <= 1'b0;
      end
    end else begin
      step_o <= 1'b0;
    end
  end

  // Digit scan runs freely, untouched by run/clear/blank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Lower-row positions run right to left, so digit = 2N-1-pos there.
  always_comb begin
    row_o    = (pos < POS_UPPER);
    digit    = row_o ? pos : POS_LAST - pos;
    enable_o = !blank_i && (digit == POS_W'(scan_idx));
    onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;
    anode_o  = led_logic ? ~onehot : onehot;
    pos_o    = pos;
  end

endmodule

// File: tb/tb_circle_ring_sequencer.sv
// Directed bench for circle_ring_sequencer with N=4, STEP_DIV=8, SCAN_DIV=2, active-low anodes.
module tb_circle_ring_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       run_i, dir_i, clear_i, blank_i;
  logic       row_o, enable_o, step_o;
  logic [3:0] anode_o;
  logic [2:0] pos_o;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int pulses;
  int en_cnt;

  circle_ring_sequencer #(
    .NUM_DIGITS(4),
    .STEP_DIV  (8),
    .SCAN_DIV  (2),
    .led_logic (1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run_i),
    .dir_i   (dir_i),
    .clear_i (clear_i),
    .blank_i (blank_i),
    .row_o   (row_o),
    .enable_o(enable_o),
    .anode_o (anode_o),
    .pos_o   (pos_o),
    .step_o  (step_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scan slot advances every 2 edges after reset release; anodes are active-low.
  function automatic logic [3:0] exp_anode();
    logic [3:0] oh;
    oh = 4'b0001 << ((ecnt / 2) % 4);
    return ~oh;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (!rst_i) ecnt++;
    chk("anode", {28'd0, anode_o}, {28'd0, exp_anode()});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_i = 1'b1; run_i = 1'b0; dir_i = 1'b0; clear_i = 1'b0; blank_i = 1'b0;
    ticks(2);
    chk("rst_pos", pos_o, 0);
    chk("rst_step", step_o, 0);
    chk("rst_row", row_o, 1);
    chk("rst_en", enable_o, 1);
    blank_i = 1'b1; #1;
    chk("rst_en_blank", enable_o, 0);
    blank_i = 1'b0;
    rst_i = 1'b0; ecnt = 0;

    // Scenario 1: reset asserted mid-run
    run_i = 1'b1;
    ticks(20);
    chk("prerst_pos", pos_o, 2);
    chk("prerst_anode", anode_o, 4'b1011);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_pos", pos_o, 0);
    chk("midrst_step", step_o, 0);
    chk("midrst_anode", anode_o, 4'b1110);
    chk("midrst_row", row_o, 1);
    chk("midrst_en", enable_o, 1);
    ecnt = 0;
    ticks(2);
    rst_i = 1'b0;

    // Scenario 2: continuous clockwise run, 72 edges
    pulses = 0;
    for (int k = 1; k <= 72; k++) begin
      tick();
      chk("cw_pos", pos_o, (k / 8) % 8);
      chk("cw_step", step_o, (k % 8 == 0) ? 1 : 0);
      if (step_o) pulses++;
    end
    chk("cw_pulses", pulses, 9);
    chk("cw_end_pos", pos_o, 1);

    // Scenario 3: counter-clockwise wrap from position 0
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_pos", pos_o, 0);
    dir_i = 1'b1;
    ticks(7);
    chk("ccw_hold", pos_o, 0);
    tick();
    chk("ccw_pos7", pos_o, 7);
    chk("ccw_step", step_o, 1);
    chk("ccw_row", row_o, 0);
    ticks(8);
    chk("ccw_pos6", pos_o, 6);
    chk("ccw_row6", row_o, 0);
    ticks(8);
    chk("ccw_pos5", pos_o, 5);

    // Scenario 4: hold pos 5 (lower circle, digit 2) and watch the scan
    run_i = 1'b0;
    en_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("hold_en", enable_o, (anode_o == 4'b1011) ? 1 : 0);
      if (enable_o) en_cnt++;
    end
    chk("hold_en_cnt", en_cnt, 2);
    while (anode_o != 4'b1011 && en_cnt < 100) begin
      tick();
      en_cnt++;
    end
    chk("hold_en_idx2", enable_o, 1);
    blank_i = 1'b1; #1;
    chk("blank_comb", enable_o, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("blank_en", enable_o, 0);
    end
    blank_i = 1'b0;
    chk("blank_pos", pos_o, 5);

    // Scenario 5: pause at step_cnt=3 for 20 cycles, then resume
    run_i = 1'b1; dir_i = 1'b0;
    ticks(3);
    run_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("pause_pos", pos_o, 5);
      chk("pause_step", step_o, 0);
    end
    run_i = 1'b1;
    ticks(4);
    chk("resume4_pos", pos_o, 5);
    tick();
    chk("resume5_pos", pos_o, 6);
    chk("resume5_step", step_o, 1);

    // Scenario 6: clear coinciding with a due step at pos 3
    dir_i = 1'b1;
    ticks(24);
    chk("pre_clr_pos", pos_o, 3);
    dir_i = 1'b0;
    ticks(7);
    chk("due_pos", pos_o, 3);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_due_pos", pos_o, 0);
    chk("clr_due_step", step_o, 0);
    ticks(7);
    chk("post_clr_hold", pos_o, 0);
    tick();
    chk("post_clr_pos", pos_o, 1);
    chk("post_clr_step", step_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
